// File: rtl/native_rr_arbiter_pkg.sv
// Shared definitions for the native round-robin arbiter family:
// FSM state encoding and the index-width helper used by arbiter and selector.
package native_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Width of a master index; a single master still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/native_rr_sel.sv
// Combinational round-robin selector: first set request bit at or above the
// pointer, wrapping at N. Shared with the multi-slave crossbar arbiters.
module native_rr_sel
    import native_rr_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Modulo keeps the candidate inside 0..N-1 even for non-power-of-2 N.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int ofs);
        int sum;
        sum = (int'(base) + ofs) % N;
        return sum[IDX_W-1:0];
    endfunction

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = wrap_add(i_ptr, k);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/native_rr_arbiter.sv
// Round-robin arbiter sharing one native slave among N_MASTERS native masters,
// one transaction at a time with an IDLE cycle between grants.
module native_rr_arbiter
    import native_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int STRB_W    = DATA_W / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            m_valid,
    output logic [N_MASTERS-1:0]            m_ready,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]     m_wstrb,
    output logic [DATA_W-1:0]               m_rdata,
    output logic                            s_valid,
    input  logic                            s_ready,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [STRB_W-1:0]               s_wstrb,
    input  logic [DATA_W-1:0]               s_rdata,
    output logic [idx_w(N_MASTERS)-1:0]     grant_o
);

    localparam int IDX_W = idx_w(N_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_any;
    logic             w_done;

    native_rr_sel #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_sel (
        .i_req (m_valid),
        .i_ptr (r_ptr),
        .o_idx (w_sel_idx),
        .o_any (w_sel_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // s_valid comes straight from the state register, so it never follows
    // m_valid combinationally and drops the moment rst is asserted.
    assign s_valid = (r_state == ST_BUSY);
    assign w_done  = s_valid & s_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_any) begin
                    w_grant_nxt = w_sel_idx;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_ready) begin
                    w_ptr_nxt   = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_ready = '0;
        if (w_done) begin
            m_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        s_addr  = m_addr[ADDR_W-1:0];
        s_wdata = m_wdata[DATA_W-1:0];
        s_wstrb = m_wstrb[STRB_W-1:0];
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_grant == IDX_W'(i)) begin
                s_addr  = m_addr[i*ADDR_W +: ADDR_W];
                s_wdata = m_wdata[i*DATA_W +: DATA_W];
                s_wstrb = m_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    assign m_rdata = s_rdata;
    assign grant_o = r_grant;

endmodule
